// File: rtl/bit_timing_logic.sv
// CAN bit timing engine: prescaler, SYNC/TSEG1/TSEG2 sequencing, hard sync and
// SJW-limited resynchronisation; emits registered sample and transmit strobes.
module bit_timing_logic #(
    parameter int BRP_W   = 6,
    parameter int TSEG1_W = 4,
    parameter int TSEG2_W = 3,
    parameter int SJW_W   = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [BRP_W-1:0]   brp,
    input  logic [TSEG1_W-1:0] tseg1,
    input  logic [TSEG2_W-1:0] tseg2,
    input  logic [SJW_W-1:0]   sjw,
    input  logic               signal_in,
    input  logic               falling_edge,
    input  logic               hard_sync_request,
    output logic               sample_point,
    output logic               sampled_bit,
    output logic               tx_point,
    output logic [1:0]         seg_state
);

    localparam int CNT_W = TSEG1_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SYNC  = 2'b01,
        TSEG1 = 2'b10,
        TSEG2 = 2'b11
    } seg_t;

    seg_t             state, state_n;
    logic [BRP_W-1:0] presc, presc_n;
    logic [CNT_W-1:0] tq_cnt, tq_cnt_n;
    logic [SJW_W-1:0] lengthen, lengthen_n;
    logic [SJW_W-1:0] shorten, shorten_n;
    logic             resync_done, resync_done_n;
    logic             sample_n, tx_n, sampled_n;
    logic             tq_tick, resync, go_sync;
    logic [CNT_W-1:0] t1_eff, t2_eff, err1, err2, sjw_ext;

    assign seg_state = state;
    assign tq_tick   = (presc == brp);
    assign sjw_ext   = CNT_W'(sjw);
    assign err1      = tq_cnt + CNT_W'(1);
    assign err2      = CNT_W'(tseg2) - tq_cnt;
    assign t2_eff    = CNT_W'(tseg2) - CNT_W'(shorten);
    assign resync    = falling_edge && !hard_sync_request && !resync_done && sampled_bit;

    always_comb begin
        state_n       = state;
        presc_n       = tq_tick ? '0 : presc + BRP_W'(1);
        tq_cnt_n      = tq_tick ? tq_cnt + CNT_W'(1) : tq_cnt;
        lengthen_n    = lengthen;
        shorten_n     = shorten;
        resync_done_n = resync_done;
        sample_n      = 1'b0;
        tx_n          = 1'b0;
        sampled_n     = sampled_bit;
        go_sync       = 1'b0;
        t1_eff        = CNT_W'(tseg1) + CNT_W'(lengthen);

        case (state)
            IDLE: begin
                state_n       = SYNC;
                tx_n          = 1'b1;
                presc_n       = '0;
                tq_cnt_n      = '0;
                lengthen_n    = '0;
                shorten_n     = '0;
                resync_done_n = 1'b0;
            end
            SYNC: begin
                if (resync)
                    resync_done_n = 1'b1;
                if (tq_tick) begin
                    state_n       = TSEG1;
                    tq_cnt_n      = '0;
                    resync_done_n = 1'b0;
                end
            end
            TSEG1: begin
                if (resync) begin
                    resync_done_n = 1'b1;
                    lengthen_n    = (err1 < sjw_ext) ? SJW_W'(err1) : sjw;
                end
                // End test uses the freshly lengthened segment so a same-clock edge extends it.
                t1_eff = CNT_W'(tseg1) + CNT_W'(lengthen_n);
                if (tq_tick && (tq_cnt == t1_eff - CNT_W'(1))) begin
                    state_n   = TSEG2;
                    tq_cnt_n  = '0;
                    sample_n  = 1'b1;
                    sampled_n = signal_in;
                end
            end
            TSEG2: begin
                if (resync) begin
                    resync_done_n = 1'b1;
                    if (err2 <= sjw_ext)
                        go_sync = 1'b1;
                    else
                        shorten_n = sjw;
                end
                // Compare with >= so a shortened phase never runs past its end.
                if (tq_tick && (tq_cnt + CNT_W'(1) >= t2_eff))
                    go_sync = 1'b1;
            end
            default: ;
        endcase

        if (go_sync || (hard_sync_request && state != IDLE)) begin
            state_n    = SYNC;
            presc_n    = '0;
            tq_cnt_n   = '0;
            lengthen_n = '0;
            shorten_n  = '0;
            tx_n       = 1'b1;
            sample_n   = 1'b0;
            sampled_n  = sampled_bit;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            presc        <= '0;
            tq_cnt       <= '0;
            lengthen     <= '0;
            shorten      <= '0;
            resync_done  <= 1'b0;
            sample_point <= 1'b0;
            tx_point     <= 1'b0;
            sampled_bit  <= 1'b1;
        end else if (!enable) begin
            state        <= IDLE;
            presc        <= '0;
            tq_cnt       <= '0;
            lengthen     <= '0;
            shorten      <= '0;
            resync_done  <= 1'b0;
            sample_point <= 1'b0;
            tx_point     <= 1'b0;
            sampled_bit  <= 1'b1;
        end else begin
            state        <= state_n;
            presc        <= presc_n;
            tq_cnt       <= tq_cnt_n;
            lengthen     <= lengthen_n;
            shorten      <= shorten_n;
            resync_done  <= resync_done_n;
            sample_point <= sample_n;
            tx_point     <= tx_n;
            sampled_bit  <= sampled_n;
        end
    end

endmodule

// File: tb/tb_bit_timing_logic.sv
// Scoreboard bench for bit_timing_logic: directed stimulus queues expected strobes
// and state snapshots by cycle; a negedge monitor pops and compares them.
module tb_bit_timing_logic;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic [5:0] brp = 6'd1;
    logic [3:0] tseg1 = 4'd5;
    logic [2:0] tseg2 = 3'd3;
    logic [1:0] sjw = 2'd1;
    logic       signal_in = 1'b1;
    logic       falling_edge = 1'b0;
    logic       hard_sync_request = 1'b0;
    logic       sample_point, sampled_bit, tx_point;
    logic [1:0] seg_state;

    bit_timing_logic #(.BRP_W(6), .TSEG1_W(4), .TSEG2_W(3), .SJW_W(2)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .enable            (enable),
        .brp               (brp),
        .tseg1             (tseg1),
        .tseg2             (tseg2),
        .sjw               (sjw),
        .signal_in         (signal_in),
        .falling_edge      (falling_edge),
        .hard_sync_request (hard_sync_request),
        .sample_point      (sample_point),
        .sampled_bit       (sampled_bit),
        .tx_point          (tx_point),
        .seg_state         (seg_state)
    );

    typedef struct {
        bit          is_tx;
        int unsigned cyc;
        bit          bitv;
    } ev_t;

    typedef struct {
        int unsigned cyc;
        logic [1:0]  seg;
        logic        sb;
        logic        sp;
        logic        tx;
    } snap_t;

    ev_t         evq[$];
    snap_t       snq[$];
    ev_t         e;
    snap_t       s;
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          done = 1'b0;

    localparam int unsigned TIMEOUT = 2000;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic push_ev(input bit is_tx, input int unsigned c, input bit b);
        ev_t x;
        x.is_tx = is_tx; x.cyc = c; x.bitv = b;
        evq.push_back(x);
    endtask

    task automatic push_snap(input int unsigned c, input logic [1:0] seg, input logic sb,
                             input logic sp, input logic tx);
        snap_t x;
        x.cyc = c; x.seg = seg; x.sb = sb; x.sp = sp; x.tx = tx;
        snq.push_back(x);
    endtask

    task automatic wait_cyc(input int unsigned n);
        while (cyc < n) @(negedge clock);
    endtask

    always @(negedge clock) begin
        if (snq.size() > 0 && snq[0].cyc <= cyc) begin
            s = snq.pop_front();
            n_cmp++;
            if (s.cyc != cyc || seg_state != s.seg || sampled_bit != s.sb ||
                sample_point != s.sp || tx_point != s.tx) begin
                n_bad++;
                $display("FAIL state@%0d: got cyc=%0d seg=%0d sb=%0b sp=%0b tx=%0b, expected seg=%0d sb=%0b sp=%0b tx=%0b",
                         s.cyc, cyc, seg_state, sampled_bit, sample_point, tx_point,
                         s.seg, s.sb, s.sp, s.tx);
            end
        end
        if (sample_point || tx_point) begin
            n_cmp++;
            if (evq.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_strobe@%0d: got sp=%0b tx=%0b, expected no strobe",
                         cyc, sample_point, tx_point);
            end else begin
                e = evq.pop_front();
                if (tx_point != e.is_tx || sample_point == e.is_tx || cyc != e.cyc ||
                    (!e.is_tx && sampled_bit != e.bitv)) begin
                    n_bad++;
                    $display("FAIL %s_strobe: got cyc=%0d sp=%0b tx=%0b sb=%0b, expected cyc=%0d bit=%0b",
                             e.is_tx ? "tx" : "sample", cyc, sample_point, tx_point,
                             sampled_bit, e.cyc, e.bitv);
                end
            end
        end
        if (done || cyc > TIMEOUT) begin
            if (!done) begin
                n_cmp++;
                n_bad++;
                $display("FAIL timeout: got cyc=%0d, expected stimulus done before %0d", cyc, TIMEOUT);
            end
            n_cmp++;
            if (evq.size() != 0 || snq.size() != 0) begin
                n_bad++;
                $display("FAIL pending: got %0d events and %0d snapshots left, expected 0 and 0",
                         evq.size(), snq.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    initial begin
        int unsigned a;
        int unsigned b;
        a = 9;
        b = a + 170;

        // Reset state and idle-with-enable-low state.
        push_snap(3, 2'b00, 1'b1, 1'b0, 1'b0);
        push_snap(6, 2'b00, 1'b1, 1'b0, 1'b0);
        push_snap(a + 2, 2'b10, 1'b1, 1'b0, 1'b0);
        push_snap(a + 70, 2'b01, 1'b1, 1'b0, 1'b1);
        push_snap(a + 105, 2'b01, 1'b1, 1'b0, 1'b1);
        push_snap(a + 164, 2'b00, 1'b1, 1'b0, 1'b0);
        push_snap(a + 167, 2'b00, 1'b1, 1'b0, 1'b0);
        push_snap(b + 16, 2'b11, 1'b1, 1'b1, 1'b0);
        push_snap(b + 45, 2'b00, 1'b1, 1'b0, 1'b0);

        // Nominal 18-clock bits, one dominant bit, hard sync, TSEG2 resyncs.
        push_ev(1, a,       0); push_ev(0, a + 12,  1);
        push_ev(1, a + 18,  0); push_ev(0, a + 30,  0);
        push_ev(1, a + 36,  0); push_ev(0, a + 48,  1);
        push_ev(1, a + 54,  0); push_ev(0, a + 66,  1);
        push_ev(1, a + 70,  0); push_ev(0, a + 82,  1);
        push_ev(1, a + 88,  0); push_ev(0, a + 100, 1);
        push_ev(1, a + 105, 0); push_ev(0, a + 117, 1);
        push_ev(1, a + 123, 0); push_ev(0, a + 135, 1);
        push_ev(1, a + 139, 0); push_ev(0, a + 151, 0);
        push_ev(1, a + 157, 0);
        // Restart after enable drop with sjw=2, TSEG1 lengthening, then reset restart.
        push_ev(1, b,       0); push_ev(0, b + 16,  1);
        push_ev(1, b + 22,  0); push_ev(0, b + 34,  0);
        push_ev(1, b + 40,  0);
        push_ev(1, b + 50,  0); push_ev(0, b + 62,  1);
        push_ev(1, b + 68,  0);

        wait_cyc(5);       reset_n = 1'b1;
        wait_cyc(a - 1);   enable = 1'b1;
        wait_cyc(a + 18);  signal_in = 1'b0;
        wait_cyc(a + 36);  signal_in = 1'b1;
        wait_cyc(a + 69);  hard_sync_request = 1'b1;
        wait_cyc(a + 70);  hard_sync_request = 1'b0;
        wait_cyc(a + 104); falling_edge = 1'b1;
        wait_cyc(a + 105); falling_edge = 1'b0;
        wait_cyc(a + 135); falling_edge = 1'b1;
        wait_cyc(a + 136); falling_edge = 1'b0;
        wait_cyc(a + 139); signal_in = 1'b0;
        wait_cyc(a + 157); signal_in = 1'b1;
        wait_cyc(a + 163); enable = 1'b0;
        wait_cyc(a + 165); sjw = 2'd2;
        wait_cyc(a + 169); enable = 1'b1;
        wait_cyc(b + 6);   falling_edge = 1'b1;
        wait_cyc(b + 7);   falling_edge = 1'b0;
        wait_cyc(b + 20);  falling_edge = 1'b1;
        wait_cyc(b + 21);  falling_edge = 1'b0;
        wait_cyc(b + 22);  signal_in = 1'b0;
        wait_cyc(b + 40);  signal_in = 1'b1;
        wait_cyc(b + 44);
        @(posedge clock);
        #2 reset_n = 1'b0;
        wait_cyc(b + 49);  reset_n = 1'b1;
        wait_cyc(b + 76);
        done = 1'b1;
    end

endmodule
